mem_stage: RTL and testbench

- Pipeline register and logic for the MEM stage of the 5-stage MIPS core.
- Sits between the EXE stage and the WB stage. Takes the EXE bundle and the synchronous data-SRAM read data (requested in EXE, returned in MEM).
- Aligns and extends load data, passes exception/CP0 tags through, and produces the MEM-to-WB bus.
- Also drives the MEM forwarding bus to decode and a kill indication back to EXE.

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/mem_stage_load_align.sv | 62 ++++++
 rtl/mem_stage.sv | 107 ++++++++++
 tb/tb_mem_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths and load-op codes for the MEM stage of the 5-stage MIPS core.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 126;
    localparam int MS_TO_WS_BUS_WD = 120;
    localparam int FW_BUS_WD       = 38;

    localparam logic [2:0] LOAD_OP_LW  = 3'd0;
    localparam logic [2:0] LOAD_OP_LB  = 3'd1;
    localparam logic [2:0] LOAD_OP_LBU = 3'd2;
    localparam logic [2:0] LOAD_OP_LH  = 3'd3;
    localparam logic [2:0] LOAD_OP_LHU = 3'd4;
    localparam logic [2:0] LOAD_OP_LWL = 3'd5;
    localparam logic [2:0] LOAD_OP_LWR = 3'd6;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load data alignment: byte/half extraction with extension and LWL/LWR merging.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  load_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] rt_value,
    output logic [31:0] result
);

    logic [7:0]  b0, b1, b2, b3;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign b0 = rdata[7:0];
    assign b1 = rdata[15:8];
    assign b2 = rdata[23:16];
    assign b3 = rdata[31:24];

    always_comb begin
        sel_byte = b0;
        case (addr_lo)
            2'd0: sel_byte = b0;
            2'd1: sel_byte = b1;
            2'd2: sel_byte = b2;
            2'd3: sel_byte = b3;
            default: sel_byte = b0;
        endcase
    end

    assign sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = rdata;
        case (load_op)
            LOAD_OP_LB:  result = {{24{sel_byte[7]}}, sel_byte};
            LOAD_OP_LBU: result = {24'd0, sel_byte};
            LOAD_OP_LH:  result = {{16{sel_half[15]}}, sel_half};
            LOAD_OP_LHU: result = {16'd0, sel_half};
            LOAD_OP_LWL: begin
                case (addr_lo)
                    2'd0: result = {b0, rt_value[23:0]};
                    2'd1: result = {b1, b0, rt_value[15:0]};
                    2'd2: result = {b2, b1, b0, rt_value[7:0]};
                    default: result = rdata;
                endcase
            end
            LOAD_OP_LWR: begin
                case (addr_lo)
                    2'd1: result = {rt_value[31:24], b3, b2, b1};
                    2'd2: result = {rt_value[31:16], b3, b2};
                    2'd3: result = {rt_value[31:8], b3};
                    default: result = rdata;
                endcase
            end
            // LW and the reserved code both return the full word
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EXE bundle, aligns load data, and feeds WB, decode forwarding and EXE kill.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic [FW_BUS_WD-1:0]       ms_to_ds_fw_bus,
    output logic                       ms_mfc0_block,
    output logic                       ms_ex_kill,
    input  logic                       ws_excp_flush,
    input  logic                       eret_flush
);

    // Handshake: a transfer happens on an edge where the producer's valid and the
    // consumer's allowin are both high; valid never depends on allowin of the same stage.
    logic                       ms_valid;
    logic                       ms_ready_go;
    logic                       flush;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;

    logic        ms_bd;
    logic [31:0] ms_rt_value;
    logic [7:0]  ms_cp0_addr;
    logic        ms_eret, ms_mtc0, ms_mfc0, ms_excp_valid;
    logic [4:0]  ms_execode;
    logic [2:0]  ms_load_op;
    logic [1:0]  ms_addr_lo;
    logic        ms_res_from_mem, ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_alu_result, ms_pc;

    logic        hold_valid;
    logic [31:0] hold_data;
    logic [31:0] rdata_eff;
    logic [31:0] load_result;
    logic [31:0] final_result;
    logic        gr_we_out;

    assign {ms_bd, ms_rt_value, ms_cp0_addr, ms_eret, ms_mtc0, ms_mfc0, ms_excp_valid,
            ms_execode, ms_load_op, ms_addr_lo, ms_res_from_mem, ms_gr_we, ms_dest,
            ms_alu_result, ms_pc} = es_to_ms_bus_r;

    assign flush          = ws_excp_flush || eret_flush;
    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            es_to_ms_bus_r <= '0;
        end else if (es_to_ms_valid && ms_allowin) begin
            es_to_ms_bus_r <= es_to_ms_bus;
        end
    end

    // SRAM data is only valid on the first MEM cycle; keep a copy while WB stalls us
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            hold_valid <= 1'b0;
            hold_data  <= 32'd0;
        end else if (ms_valid && ms_allowin) begin
            hold_valid <= 1'b0;
        end else if (ms_valid && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_data  <= data_sram_rdata;
        end
    end

    assign rdata_eff = hold_valid ? hold_data : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .load_op  (ms_load_op),
        .addr_lo  (ms_addr_lo),
        .rdata    (rdata_eff),
        .rt_value (ms_rt_value),
        .result   (load_result)
    );

    // mfc0 result is substituted with CP0 data in WB
    assign final_result = ms_mfc0         ? 32'd0 :
                          ms_res_from_mem ? load_result : ms_alu_result;
    assign gr_we_out    = ms_gr_we && !ms_excp_valid;

    assign ms_to_ws_bus = {ms_bd, ms_rt_value, ms_cp0_addr, ms_eret, ms_mtc0, ms_mfc0,
                           ms_excp_valid, ms_execode, gr_we_out, ms_dest,
                           final_result, ms_pc};

    assign ms_to_ds_fw_bus = {ms_valid && gr_we_out && !ms_mfc0, ms_dest, final_result};
    assign ms_mfc0_block   = ms_valid && ms_mfc0;
    assign ms_ex_kill      = ms_valid && (ms_excp_valid || ms_eret);

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage with hand-computed expectations.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                       clk;
    logic                       reset;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ws_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [31:0]                data_sram_rdata;
    logic [FW_BUS_WD-1:0]       ms_to_ds_fw_bus;
    logic                       ms_mfc0_block;
    logic                       ms_ex_kill;
    logic                       ws_excp_flush;
    logic                       eret_flush;

    int vectors;
    int miscompares;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ws_allowin      (ws_allowin),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_to_ds_fw_bus (ms_to_ds_fw_bus),
        .ms_mfc0_block   (ms_mfc0_block),
        .ms_ex_kill      (ms_ex_kill),
        .ws_excp_flush   (ws_excp_flush),
        .eret_flush      (eret_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ms_to_ws_bus field views
    logic [31:0] wb_pc, wb_result;
    logic [4:0]  wb_dest, wb_execode;
    logic        wb_gr_we, wb_excp;
    logic        fw_we;
    logic [4:0]  fw_dest;
    logic [31:0] fw_data;
    assign wb_pc      = ms_to_ws_bus[31:0];
    assign wb_result  = ms_to_ws_bus[63:32];
    assign wb_dest    = ms_to_ws_bus[68:64];
    assign wb_gr_we   = ms_to_ws_bus[69];
    assign wb_execode = ms_to_ws_bus[74:70];
    assign wb_excp    = ms_to_ws_bus[75];
    assign fw_we      = ms_to_ds_fw_bus[37];
    assign fw_dest    = ms_to_ds_fw_bus[36:32];
    assign fw_data    = ms_to_ds_fw_bus[31:0];

    function automatic logic [ES_TO_MS_BUS_WD-1:0] mk_es(
        input logic [31:0] rt, input logic eret, input logic mfc0, input logic excp,
        input logic [4:0] execode, input logic [2:0] load_op, input logic [1:0] addr_lo,
        input logic res_from_mem, input logic gr_we, input logic [4:0] dest,
        input logic [31:0] alu, input logic [31:0] pc);
        return {1'b0, rt, 8'h00, eret, 1'b0, mfc0, excp, execode,
                load_op, addr_lo, res_from_mem, gr_we, dest, alu, pc};
    endfunction

    function automatic logic [ES_TO_MS_BUS_WD-1:0] mk_load(
        input logic [2:0] op, input logic [1:0] lo, input logic [31:0] rt, input logic [31:0] pc);
        return mk_es(rt, 1'b0, 1'b0, 1'b0, 5'd0, op, lo, 1'b1, 1'b1, 5'd5, 32'h0000_1000, pc);
    endfunction

    task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one bundle for one edge, then withdraw it
    task automatic issue(input logic [ES_TO_MS_BUS_WD-1:0] bus);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = bus;
        step();
        es_to_ms_valid = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        ws_allowin = 1'b1;
        data_sram_rdata = 32'd0;
        ws_excp_flush = 1'b0;
        eret_flush = 1'b0;

        // reset state
        step();
        step();
        chk("rst_to_ws_valid", ms_to_ws_valid, 0);
        chk("rst_allowin", ms_allowin, 1);
        chk("rst_mfc0_block", ms_mfc0_block, 0);
        chk("rst_ex_kill", ms_ex_kill, 0);
        chk("rst_fw_we", fw_we, 0);
        chk("rst_bus", ms_to_ws_bus, 0);
        reset = 1'b0;
        step();

        // LB / LBU, byte 3
        issue(mk_load(LOAD_OP_LB, 2'd3, 32'd0, 32'hBFC0_0010));
        data_sram_rdata = 32'h8011_2233;
        #1;
        chk("lb_valid", ms_to_ws_valid, 1);
        chk("lb_result", wb_result, 32'hFFFF_FF80);
        chk("lb_gr_we", wb_gr_we, 1);
        chk("lb_fw_we", fw_we, 1);
        chk("lb_fw_dest", fw_dest, 5'd5);
        chk("lb_fw_data", fw_data, 32'hFFFF_FF80);
        chk("lb_pc", wb_pc, 32'hBFC0_0010);

        issue(mk_load(LOAD_OP_LBU, 2'd3, 32'd0, 32'hBFC0_0014));
        #1;
        chk("lbu_result", wb_result, 32'h0000_0080);

        // LH sign, LHU zero, upper half
        issue(mk_load(LOAD_OP_LH, 2'd2, 32'd0, 32'hBFC0_0018));
        #1;
        chk("lh_result", wb_result, 32'hFFFF_8011);
        issue(mk_load(LOAD_OP_LHU, 2'd0, 32'd0, 32'hBFC0_001C));
        #1;
        chk("lhu_result", wb_result, 32'h0000_2233);

        // LWL / LWR merges
        issue(mk_load(LOAD_OP_LWL, 2'd1, 32'h1122_3344, 32'hBFC0_0020));
        data_sram_rdata = 32'hAABB_CCDD;
        #1;
        chk("lwl_result", wb_result, 32'hCCDD_3344);
        issue(mk_load(LOAD_OP_LWR, 2'd2, 32'h1122_3344, 32'hBFC0_0024));
        #1;
        chk("lwr_result", wb_result, 32'h1122_AABB);
        issue(mk_load(3'd7, 2'd1, 32'h1122_3344, 32'hBFC0_0028));
        #1;
        chk("rsvd_result", wb_result, 32'hAABB_CCDD);

        // WB stall with LW in MEM; rdata goes stale after first MEM cycle
        issue(mk_load(LOAD_OP_LW, 2'd0, 32'd0, 32'hBFC0_0030));
        ws_allowin = 1'b0;
        data_sram_rdata = 32'h1234_5678;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(32'd0, 1'b0, 1'b0, 1'b0, 5'd0, LOAD_OP_LW, 2'd0, 1'b0, 1'b1,
                             5'd9, 32'hDEAD_BEEF, 32'hBFC0_0034);
        #1;
        chk("stall0_allowin", ms_allowin, 0);
        chk("stall0_result", wb_result, 32'h1234_5678);
        for (int i = 1; i <= 2; i++) begin
            step();
            data_sram_rdata = 32'hFFFF_0000 + i;
            #1;
            chk("stall_allowin", ms_allowin, 0);
            chk("stall_valid", ms_to_ws_valid, 1);
            chk("stall_result", wb_result, 32'h1234_5678);
            chk("stall_pc", wb_pc, 32'hBFC0_0030);
        end
        ws_allowin = 1'b1;
        #1;
        chk("stall_release_result", wb_result, 32'h1234_5678);
        step();
        es_to_ms_valid = 1'b0;
        #1;
        chk("after_stall_pc", wb_pc, 32'hBFC0_0034);
        chk("after_stall_result", wb_result, 32'hDEAD_BEEF);

        // Excepting instruction
        issue(mk_es(32'd0, 1'b0, 1'b0, 1'b1, 5'h04, LOAD_OP_LW, 2'd0, 1'b0, 1'b1,
                    5'd7, 32'h0000_0042, 32'hBFC0_0040));
        #1;
        chk("exc_gr_we", wb_gr_we, 0);
        chk("exc_execode", wb_execode, 5'h04);
        chk("exc_excp", wb_excp, 1);
        chk("exc_kill", ms_ex_kill, 1);
        chk("exc_fw_we", fw_we, 0);

        // Flush with a new EXE instruction waiting
        issue(mk_es(32'd0, 1'b0, 1'b0, 1'b0, 5'd0, LOAD_OP_LW, 2'd0, 1'b0, 1'b1,
                    5'd3, 32'h0000_0055, 32'hBFC0_0050));
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(32'd0, 1'b0, 1'b0, 1'b0, 5'd0, LOAD_OP_LW, 2'd0, 1'b0, 1'b1,
                             5'd4, 32'h0000_0066, 32'hBFC0_0054);
        ws_excp_flush = 1'b1;
        #1;
        chk("flush_to_ws_valid", ms_to_ws_valid, 0);
        step();
        ws_excp_flush = 1'b0;
        es_to_ms_valid = 1'b0;
        #1;
        chk("flush_next_valid", ms_to_ws_valid, 0);
        chk("flush_next_allowin", ms_allowin, 1);
        chk("flush_next_fw_we", fw_we, 0);

        // eret in MEM raises kill, eret_flush drops it
        issue(mk_es(32'd0, 1'b1, 1'b0, 1'b0, 5'd0, LOAD_OP_LW, 2'd0, 1'b0, 1'b0,
                    5'd0, 32'd0, 32'hBFC0_0060));
        #1;
        chk("eret_kill", ms_ex_kill, 1);
        eret_flush = 1'b1;
        #1;
        chk("eret_flush_valid", ms_to_ws_valid, 0);
        step();
        eret_flush = 1'b0;
        #1;
        chk("eret_after_kill", ms_ex_kill, 0);

        // mfc0
        issue(mk_es(32'd0, 1'b0, 1'b1, 1'b0, 5'd0, LOAD_OP_LW, 2'd0, 1'b0, 1'b1,
                    5'd8, 32'h7777_7777, 32'hBFC0_0070));
        #1;
        chk("mfc0_block", ms_mfc0_block, 1);
        chk("mfc0_fw_we", fw_we, 0);
        chk("mfc0_result", wb_result, 32'd0);
        chk("mfc0_gr_we", wb_gr_we, 1);

        // Reset in the middle of a stall
        issue(mk_load(LOAD_OP_LW, 2'd0, 32'd0, 32'hBFC0_0080));
        ws_allowin = 1'b0;
        data_sram_rdata = 32'h5555_AAAA;
        step();
        reset = 1'b1;
        step();
        chk("rst2_valid", ms_to_ws_valid, 0);
        chk("rst2_allowin", ms_allowin, 1);
        chk("rst2_block", ms_mfc0_block, 0);
        chk("rst2_kill", ms_ex_kill, 0);
        chk("rst2_fw_we", fw_we, 0);
        reset = 1'b0;
        ws_allowin = 1'b1;
        step();

        // Hold flag must be clear: fresh load sees live rdata
        issue(mk_load(LOAD_OP_LW, 2'd0, 32'd0, 32'hBFC0_0090));
        data_sram_rdata = 32'hCAFE_F00D;
        #1;
        chk("post_rst_result", wb_result, 32'hCAFE_F00D);
        chk("post_rst_valid", ms_to_ws_valid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
